// File: rtl/audio_pdm_cic_rx.sv
// Stereo PDM receiver: 2-flop input sync, per-channel 3rd-order CIC decimator, offset-binary PCM out.
// Optional define PDM_RX_CLIP_FLAG_EN adds clip_l/clip_r saturation flags.
module audio_pdm_cic_rx #(
  parameter int DECIM_LOG2 = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ock,
  input  logic        sdi,
  output logic [31:0] dout_l,
  output logic [31:0] dout_r,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        overrun
`ifdef PDM_RX_CLIP_FLAG_EN
  ,
  output logic        clip_l,
  output logic        clip_r
`endif
);

  localparam int W = 3 * DECIM_LOG2 + 2;
  localparam int G = 3 * DECIM_LOG2;
  localparam logic signed [W-1:0] SAT_MAX = W'((1 << G) - 1);

  // state  | meaning
  // IDLE   | waiting for the decimation counter to wrap
  // COMB_L | left comb chain on the left i3 snapshot
  // COMB_R | right comb chain on the right i3 snapshot
  // OUT    | convert and present the PCM pair (after warm-up)
  typedef enum logic [1:0] {IDLE, COMB_L, COMB_R, OUT} state_t;
  state_t state, state_nx;

  logic ock_d, ock_dd, sdi_d, sdi_dd;
  logic rise, fall, wrap;
  logic [W-1:0] x;
  logic [W-1:0] i1_l, i2_l, i3_l, i1_r, i2_r, i3_r;
  logic [W-1:0] i1_n, i2_n, i3_n;
  logic [DECIM_LOG2-1:0] cnt;
  logic [W-1:0] snap_l, snap_r;
  logic [W-1:0] d1_l, d2_l, d3_l, d1_r, d2_r, d3_r;
  logic [W-1:0] comb_in, z1, z2, z3, c1, c2, c3;
  logic signed [W-1:0] c3_l, c3_r;
  logic [1:0] warm;
  logic handshake;

  function automatic logic [31:0] to_pcm(input logic signed [W-1:0] c);
    // c3 never drops below -2^G, so only the top needs clamping
    if (c > SAT_MAX) return {{(G+1){1'b1}}, {(31-G){1'b0}}};
    else             return {~c[G], c[G-1:0], {(31-G){1'b0}}};
  endfunction

  assign rise      = ~ock_dd & ock_d;
  assign fall      = ock_dd & ~ock_d;
  assign wrap      = fall & (&cnt);
  assign x         = sdi_dd ? W'(1) : {W{1'b1}};
  assign handshake = dout_valid & dout_ready;

  // Edges are mutually exclusive, so one adder chain serves both channels
  always_comb begin
    i1_n = (rise ? i1_l : i1_r) + x;
    i2_n = (rise ? i2_l : i2_r) + i1_n;
    i3_n = (rise ? i3_l : i3_r) + i2_n;
  end

  always_comb begin
    comb_in = snap_l;
    z1      = d1_l;
    z2      = d2_l;
    z3      = d3_l;
    if (state == COMB_R) begin
      comb_in = snap_r;
      z1      = d1_r;
      z2      = d2_r;
      z3      = d3_r;
    end
    c1 = comb_in - z1;
    c2 = c1 - z2;
    c3 = c2 - z3;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (wrap) state_nx = COMB_L;
      COMB_L:  state_nx = COMB_R;
      COMB_R:  state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ock_d  <= 1'b0;
      ock_dd <= 1'b0;
      sdi_d  <= 1'b0;
      sdi_dd <= 1'b0;
      i1_l   <= '0;
      i2_l   <= '0;
      i3_l   <= '0;
      i1_r   <= '0;
      i2_r   <= '0;
      i3_r   <= '0;
      cnt    <= '0;
      snap_l <= '0;
      snap_r <= '0;
    end else begin
      ock_d  <= ock;
      ock_dd <= ock_d;
      sdi_d  <= sdi;
      sdi_dd <= sdi_d;
      if (rise) begin
        i1_l <= i1_n;
        i2_l <= i2_n;
        i3_l <= i3_n;
      end
      if (fall) begin
        i1_r <= i1_n;
        i2_r <= i2_n;
        i3_r <= i3_n;
        cnt  <= cnt + 1'b1;
      end
      // right snapshot includes the sample that completes the frame
      if (wrap) begin
        snap_l <= i3_l;
        snap_r <= i3_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d1_l <= '0;
      d2_l <= '0;
      d3_l <= '0;
      d1_r <= '0;
      d2_r <= '0;
      d3_r <= '0;
      c3_l <= '0;
      c3_r <= '0;
    end else if (state == COMB_L) begin
      d1_l <= snap_l;
      d2_l <= c1;
      d3_l <= c2;
      c3_l <= c3;
    end else if (state == COMB_R) begin
      d1_r <= snap_r;
      d2_r <= c1;
      d3_r <= c2;
      c3_r <= c3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_l     <= 32'h8000_0000;
      dout_r     <= 32'h8000_0000;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
      warm       <= '0;
`ifdef PDM_RX_CLIP_FLAG_EN
      clip_l     <= 1'b0;
      clip_r     <= 1'b0;
`endif
    end else if (state == OUT && warm != 2'd3) begin
      warm <= warm + 1'b1;
      if (handshake) dout_valid <= 1'b0;
`ifdef PDM_RX_CLIP_FLAG_EN
      if (handshake) begin
        clip_l <= 1'b0;
        clip_r <= 1'b0;
      end
`endif
    end else if (state == OUT) begin
      dout_l     <= to_pcm(c3_l);
      dout_r     <= to_pcm(c3_r);
      dout_valid <= 1'b1;
      if (dout_valid && !dout_ready) overrun <= 1'b1;
`ifdef PDM_RX_CLIP_FLAG_EN
      clip_l     <= c3_l > SAT_MAX;
      clip_r     <= c3_r > SAT_MAX;
`endif
    end else if (handshake) begin
      dout_valid <= 1'b0;
`ifdef PDM_RX_CLIP_FLAG_EN
      clip_l     <= 1'b0;
      clip_r     <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_audio_pdm_cic_rx.sv
// Bench for audio_pdm_cic_rx: randomized PDM frames against a moving-sum CIC reference model.
module tb_audio_pdm_cic_rx;
  localparam int DL = 6;
  localparam int R  = 1 << DL;
  localparam int G  = 3 * DL;

  logic clk = 1'b0;
  logic rst, ock, sdi, dout_ready;
  logic [31:0] dout_l, dout_r;
  logic dout_valid, overrun;
`ifdef PDM_RX_CLIP_FLAG_EN
  logic clip_l, clip_r;
  logic exp_cl, exp_cr;
`endif

  always #5 clk = ~clk;

  audio_pdm_cic_rx #(.DECIM_LOG2(DL)) dut (
    .clk(clk), .rst(rst), .ock(ock), .sdi(sdi),
    .dout_l(dout_l), .dout_r(dout_r), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .overrun(overrun)
`ifdef PDM_RX_CLIP_FLAG_EN
    , .clip_l(clip_l), .clip_r(clip_r)
`endif
  );

  int checks = 0;
  int errors = 0;
  int xq_l[$];
  int xq_r[$];
  int fc;
  logic exp_valid, exp_ovr;
  logic [31:0] exp_l, exp_r, obs_l, obs_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint xs(input int ch, input int m);
    if (m < 1) return 0;
    return (ch == 0) ? longint'(xq_l[m-1]) : longint'(xq_r[m-1]);
  endfunction

  // Three cascaded length-R moving sums of the +/-1 stream, read at the frame end
  function automatic longint cic_ref(input int ch);
    int n = fc * R;
    longint s1[];
    longint s2[];
    longint s3 = 0;
    s1 = new[n + 1];
    s2 = new[n + 1];
    for (int p = 1; p <= n; p++) begin
      s1[p] = 0;
      for (int c = 0; c < R; c++) s1[p] += xs(ch, p - c);
    end
    for (int q = 1; q <= n; q++) begin
      s2[q] = 0;
      for (int b = 0; b < R && q - b >= 1; b++) s2[q] += s1[q - b];
    end
    for (int a = 0; a < R && n - a >= 1; a++) s3 += s2[n - a];
    return s3;
  endfunction

  function automatic logic [31:0] pcm(input longint c);
    longint top = (longint'(1) << G) - 1;
    longint s = (c > top) ? top : c;
    longint u = s + (longint'(1) << G);
    return 32'(u << (31 - G));
  endfunction

  task automatic model_reset();
    xq_l.delete();
    xq_r.delete();
    fc = 0;
    exp_valid = 1'b0;
    exp_ovr = 1'b0;
    exp_l = 32'h8000_0000;
    exp_r = 32'h8000_0000;
`ifdef PDM_RX_CLIP_FLAG_EN
    exp_cl = 1'b0;
    exp_cr = 1'b0;
`endif
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_dout_l"}, dout_l, 32'h8000_0000);
    chk({tag, "_dout_r"}, dout_r, 32'h8000_0000);
    chk({tag, "_valid"}, {31'b0, dout_valid}, 32'd0);
    chk({tag, "_overrun"}, {31'b0, overrun}, 32'd0);
  endtask

  // One L/R bit pair: 8 clk per ock period, sdi settled 2 clk before each ock edge
  task automatic pair(input bit l, input bit r);
    sdi = l;
    repeat (2) @(negedge clk);
    ock = 1'b1;
    repeat (2) @(negedge clk);
    sdi = r;
    repeat (2) @(negedge clk);
    ock = 1'b0;
    repeat (2) @(negedge clk);
    xq_l.push_back(l ? 1 : -1);
    xq_r.push_back(r ? 1 : -1);
  endtask

  // mode 0: all ones; 1: L=1 R=0; 2: L alternating, R random; 3: both random
  task automatic run_frame(input int mode, input bit inject_rst);
    longint cl, cr;
    for (int i = 0; i < R; i++) begin
      bit l, r;
      case (mode)
        0:       begin l = 1'b1; r = 1'b1; end
        1:       begin l = 1'b1; r = 1'b0; end
        2:       begin l = (i % 2 == 0); r = 1'($urandom_range(0, 1)); end
        default: begin l = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1)); end
      endcase
      pair(l, r);
    end
    if (inject_rst) begin
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      check_reset_values("midrst");
      return;
    end
    fc++;
    @(negedge clk);
    @(negedge clk);
    chk("valid_before_latency", {31'b0, dout_valid}, {31'b0, exp_valid});
    if (fc >= 4) begin
      cl = cic_ref(0);
      cr = cic_ref(1);
      if (exp_valid && !dout_ready) exp_ovr = 1'b1;
      exp_l = pcm(cl);
      exp_r = pcm(cr);
      exp_valid = 1'b1;
`ifdef PDM_RX_CLIP_FLAG_EN
      exp_cl = cl > (longint'(1) << G) - 1;
      exp_cr = cr > (longint'(1) << G) - 1;
`endif
    end
    @(negedge clk);
    obs_l = dout_l;
    obs_r = dout_r;
    chk("valid_at_latency", {31'b0, dout_valid}, {31'b0, exp_valid});
    chk("dout_l", dout_l, exp_l);
    chk("dout_r", dout_r, exp_r);
    chk("overrun", {31'b0, overrun}, {31'b0, exp_ovr});
`ifdef PDM_RX_CLIP_FLAG_EN
    chk("clip_l", {31'b0, clip_l}, {31'b0, exp_cl});
    chk("clip_r", {31'b0, clip_r}, {31'b0, exp_cr});
`endif
    @(negedge clk);
    if (dout_ready) begin
      exp_valid = 1'b0;
`ifdef PDM_RX_CLIP_FLAG_EN
      exp_cl = 1'b0;
      exp_cr = 1'b0;
`endif
    end
    chk("valid_after_pulse", {31'b0, dout_valid}, {31'b0, exp_valid});
  endtask

  initial begin
    rst = 1'b1;
    ock = 1'b0;
    sdi = 1'b0;
    dout_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_reset_values("reset");

    // warm-up with full-scale positive input, frame 4 saturates
    for (int f = 0; f < 4; f++) run_frame(0, 1'b0);
    chk("const1_l", obs_l, 32'hFFFF_E000);
    chk("const1_r", obs_r, 32'hFFFF_E000);

    for (int f = 0; f < 3; f++) run_frame(1, 1'b0);
    chk("split_l", obs_l, 32'hFFFF_E000);
    chk("split_r", obs_r, 32'h0000_0000);

    for (int f = 0; f < 3; f++) run_frame(2, 1'b0);
    chk("alt_l_mid", obs_l, 32'h8000_0000);

    for (int f = 0; f < 2; f++) run_frame(3, 1'b0);

    // backpressure across two presented frames
    dout_ready = 1'b0;
    run_frame(3, 1'b0);
    run_frame(3, 1'b0);
    chk("overrun_set", {31'b0, overrun}, 32'd1);
    dout_ready = 1'b1;
    @(negedge clk);
    exp_valid = 1'b0;
`ifdef PDM_RX_CLIP_FLAG_EN
    exp_cl = 1'b0;
    exp_cr = 1'b0;
    chk("clip_l_cleared", {31'b0, clip_l}, 32'd0);
`endif
    chk("valid_drop_on_ready", {31'b0, dout_valid}, 32'd0);
    chk("overrun_sticky", {31'b0, overrun}, 32'd1);
    run_frame(3, 1'b0);

    // reset during COMB_R, then warm-up restarts
    run_frame(3, 1'b1);
    for (int f = 0; f < 4; f++) run_frame(3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
